// File: rtl/stepdisp_pkg.sv
// Shared definitions for the step button / 7-segment display controller:
// field-select encodings, hex glyph table and default timing constants.
package stepdisp_pkg;

  localparam int unsigned DB_CNT_DEF   = 500000;
  localparam int unsigned SCAN_CNT_DEF = 50000;

  typedef enum logic [1:0] {
    SEL_PC_LO  = 2'b00,
    SEL_PC_HI  = 2'b01,
    SEL_INS_LO = 2'b10,
    SEL_INS_HI = 2'b11
  } sel_t;

  // Active-low {g,f,e,d,c,b,a} glyphs, index = nibble value (F at the top, 0 at the bottom).
  localparam logic [15:0][6:0] HEX_SEG = {
    7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

endpackage

// File: rtl/step_display_ctrl_debounce.sv
// Button conditioning: 2-FF synchronizer, debounce qualifier and a
// one-cycle pulse on each accepted press.
import stepdisp_pkg::*;

module button_debounce #(
  parameter int unsigned DB_CNT = DB_CNT_DEF
) (
  input  logic CLK,
  input  logic RST,
  input  logic btn,
  output logic pulse
);

  localparam int unsigned CW = (DB_CNT > 1) ? $clog2(DB_CNT) : 1;

  logic          sync1;
  logic          synced;
  logic          stable;
  logic          stable_d;
  logic [CW-1:0] db_cnt;

  // The counter only runs while the synced level differs from the accepted
  // level; any return to the accepted level restarts the qualification window.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      sync1    <= 1'b0;
      synced   <= 1'b0;
      stable   <= 1'b0;
      stable_d <= 1'b0;
      db_cnt   <= '0;
      pulse    <= 1'b0;
    end else begin
      sync1    <= btn;
      synced   <= sync1;
      stable_d <= stable;
      pulse    <= stable & ~stable_d;
      if (synced == stable) begin
        db_cnt <= '0;
      end else if (db_cnt == CW'(DB_CNT - 1)) begin
        stable <= synced;
        db_cnt <= '0;
      end else begin
        db_cnt <= db_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/step_display_ctrl.sv
// Board-side companion to the multicycle CPU: single-step pulse generation
// and a 4-digit multiplexed 7-segment view of the selected PC/instruction half.
import stepdisp_pkg::*;

module step_display_ctrl #(
  parameter int unsigned DB_CNT   = DB_CNT_DEF,
  parameter int unsigned SCAN_CNT = SCAN_CNT_DEF
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        btn_step,
  input  logic [1:0]  sw_sel,
  input  logic [31:0] now_pc,
  input  logic [31:0] ins,
  output logic        step_pulse,
  output logic [15:0] step_count,
  output logic [3:0]  an,
  output logic [6:0]  seg
);

  localparam int unsigned SW = (SCAN_CNT > 1) ? $clog2(SCAN_CNT) : 1;

  logic [SW-1:0] scan_cnt;
  logic [1:0]    idx;
  logic [1:0]    idx_next;
  logic [15:0]   disp_reg;
  logic [15:0]   disp_next;
  logic [15:0]   field;
  logic          started;
  logic          scan_wrap;

  button_debounce #(.DB_CNT(DB_CNT)) u_debounce (
    .CLK   (CLK),
    .RST   (RST),
    .btn   (btn_step),
    .pulse (step_pulse)
  );

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      step_count <= '0;
    end else if (step_pulse) begin
      step_count <= step_count + 16'd1;
    end
  end

  always_comb begin
    field = '0;
    case (sel_t'(sw_sel))
      SEL_PC_LO:  field = now_pc[15:0];
      SEL_PC_HI:  field = now_pc[31:16];
      SEL_INS_LO: field = ins[15:0];
      SEL_INS_HI: field = ins[31:16];
      default:    field = '0;
    endcase
    scan_wrap = (scan_cnt == SW'(SCAN_CNT - 1));
    idx_next  = scan_wrap ? idx + 2'd1 : idx;
    disp_next = (scan_wrap || !started) ? field : disp_reg;
  end

  // an/seg are built from the next-state index and data so that a digit and
  // its freshly latched nibble appear on the same edge.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      started  <= 1'b0;
      scan_cnt <= '0;
      idx      <= '0;
      disp_reg <= '0;
      an       <= '1;
      seg      <= '1;
    end else begin
      started  <= 1'b1;
      scan_cnt <= scan_wrap ? '0 : scan_cnt + 1'b1;
      idx      <= idx_next;
      disp_reg <= disp_next;
      an       <= ~(4'b0001 << idx_next);
      seg      <= HEX_SEG[disp_next[{idx_next, 2'b00} +: 4]];
    end
  end

endmodule

// File: tb/tb_step_display_ctrl.sv
// Directed bench for step_display_ctrl with a display scoreboard and
// pulse monitor (DB_CNT=8, SCAN_CNT=4).
module tb_step_display_ctrl;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        btn_step = 1'b0;
  logic [1:0]  sw_sel = 2'b00;
  logic [31:0] now_pc = '0;
  logic [31:0] ins = '0;
  logic        step_pulse;
  logic [15:0] step_count;
  logic [3:0]  an;
  logic [6:0]  seg;

  typedef struct {
    logic [3:0] an;
    logic [6:0] seg;
  } exp_t;

  exp_t        q[$];
  int          vectors = 0;
  int          miscompares = 0;
  int          cyc = 0;
  int          pulse_total = 0;
  int          last_pulse_cyc = 0;
  logic [3:0]  prev_an = 4'hF;

  step_display_ctrl #(.DB_CNT(8), .SCAN_CNT(4)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .btn_step   (btn_step),
    .sw_sel     (sw_sel),
    .now_pc     (now_pc),
    .ins        (ins),
    .step_pulse (step_pulse),
    .step_count (step_count),
    .an         (an),
    .seg        (seg)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  always @(negedge CLK) begin
    if (step_pulse === 1'b1) begin
      pulse_total    <= pulse_total + 1;
      last_pulse_cyc <= cyc;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [3:0] a, input logic [6:0] s);
    exp_t e;
    e.an  = a;
    e.seg = s;
    q.push_back(e);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic run_display(input int budget);
    exp_t e;
    int   n = 0;
    while (q.size() > 0 && n < budget) begin
      @(negedge CLK);
      n++;
      if (an !== prev_an) begin
        prev_an = an;
        if (an !== 4'hF) begin
          e = q.pop_front();
          vectors++;
          assert (an === e.an && seg === e.seg) else begin
            miscompares++;
            $error("FAIL disp observed an=%h seg=%h expected an=%h seg=%h", an, seg, e.an, e.seg);
          end
        end
      end
    end
    if (q.size() > 0) begin
      vectors++;
      miscompares++;
      $error("FAIL disp_timeout observed pending=%0d expected pending=0", q.size());
      q.delete();
    end
  endtask

  task automatic enter_reset();
    tick(1);
    RST = 1'b0;
    tick(3);
    prev_an = 4'hF;
  endtask

  initial begin
    int rise;
    int p0;

    // 1: reset holds outputs while inputs wiggle
    for (int i = 0; i < 10; i++) begin
      btn_step = i[0];
      sw_sel   = i[1:0];
      now_pc   = 32'h1111_1111 * i;
      @(negedge CLK);
      check("rst_an", 32'(an), 32'hF);
      check("rst_seg", 32'(seg), 32'h7F);
      check("rst_pulse", 32'(step_pulse), 32'h0);
      check("rst_count", 32'(step_count), 32'h0);
    end
    btn_step = 1'b0;
    sw_sel   = 2'b00;
    tick(1);
    RST = 1'b1;
    tick(20);

    // 2: clean press, 11-cycle latency, single pulse, none on release
    p0   = pulse_total;
    btn_step = 1'b1;
    rise = cyc;
    tick(20);
    check("press_pulses", 32'(pulse_total - p0), 32'd1);
    check("press_latency", 32'(last_pulse_cyc - rise), 32'd11);
    check("press_count", 32'(step_count), 32'd1);
    btn_step = 1'b0;
    tick(20);
    check("release_pulses", 32'(pulse_total - p0), 32'd1);

    // 3: bouncy press then a short glitch
    p0 = pulse_total;
    for (int i = 0; i < 3; i++) begin
      btn_step = 1'b1;
      tick(3);
      btn_step = 1'b0;
      tick(2);
    end
    btn_step = 1'b1;
    tick(20);
    check("bounce_pulses", 32'(pulse_total - p0), 32'd1);
    check("bounce_count", 32'(step_count), 32'd2);
    btn_step = 1'b0;
    tick(20);
    p0 = pulse_total;
    btn_step = 1'b1;
    tick(5);
    btn_step = 1'b0;
    tick(20);
    check("glitch_pulses", 32'(pulse_total - p0), 32'd0);
    check("glitch_count", 32'(step_count), 32'd2);

    // 4: PC low half 0x1234, digits scanned right to left
    enter_reset();
    now_pc = 32'h0000_1234;
    sw_sel = 2'b00;
    push(4'hE, 7'h19);
    push(4'hD, 7'h30);
    push(4'hB, 7'h24);
    push(4'h7, 7'h79);
    RST = 1'b1;
    run_display(60);

    // 5: select change mid-digit lands at the next digit boundary
    enter_reset();
    ins    = 32'hDEAD_BEEF;
    sw_sel = 2'b10;
    push(4'hE, 7'h0E);
    push(4'hD, 7'h08);
    push(4'hB, 7'h06);
    push(4'h7, 7'h21);
    RST = 1'b1;
    tick(1);
    sw_sel = 2'b11;
    tick(1);
    check("tear_an", 32'(an), 32'hE);
    check("tear_seg", 32'(seg), 32'h0E);
    run_display(60);

    // 6: step_count wrap via forced pulses, then reset during debounce
    enter_reset();
    RST = 1'b1;
    tick(2);
    force dut.step_pulse = 1'b1;
    tick(65535);
    check("wrap_ffff", 32'(step_count), 32'hFFFF);
    tick(1);
    release dut.step_pulse;
    check("wrap_zero", 32'(step_count), 32'h0);
    tick(20);
    p0 = pulse_total;
    btn_step = 1'b1;
    tick(6);
    RST = 1'b0;
    btn_step = 1'b0;
    tick(3);
    RST = 1'b1;
    tick(30);
    check("midrst_pulses", 32'(pulse_total - p0), 32'd0);
    check("midrst_count", 32'(step_count), 32'd0);
    btn_step = 1'b1;
    rise = cyc;
    tick(20);
    check("restart_count", 32'(step_count), 32'd1);
    check("restart_latency", 32'(last_pulse_cyc - rise), 32'd11);
    btn_step = 1'b0;
    tick(5);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
